// File: rtl/buffer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// buffer_ctrl_pkg
// Shared definitions for the circular-buffer pointer/occupancy controller:
//   - addr_w()  : address width for a SIZE-word buffer
//   - cnt_w()   : occupancy counter width (must hold 0..SIZE inclusive)
//   - op_e      : per-cycle handshake outcome, encoded as {read, write}
// -----------------------------------------------------------------------------
package buffer_ctrl_pkg;

  localparam int DEF_SIZE  = 16;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_K     = 4;
  localparam int DEF_J     = 8;

  function automatic int addr_w(input int size);
    return $clog2(size);
  endfunction

  // One extra bit so that a completely full buffer (count == SIZE) is representable.
  function automatic int cnt_w(input int size);
    return $clog2(size) + 1;
  endfunction

  // Encoding matches {read_fire, write_fire} so a plain cast decodes it.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/buffer_ctrl_mod_ptr.sv
// -----------------------------------------------------------------------------
// buffer_ctrl_mod_ptr
// Wrapping pointer register. Advances by STEP (mod SIZE) when i_adv is high;
// the addition is BIT bits wide, so overflow past SIZE-1 wraps naturally.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset (pointer -> 0)
//   i_clr  in   synchronous clear, priority over i_adv
//   i_adv  in   advance the pointer by STEP this cycle
//   o_ptr  out  current pointer value (registered)
// -----------------------------------------------------------------------------
module buffer_ctrl_mod_ptr
  import buffer_ctrl_pkg::*;
#(
  parameter  int SIZE = DEF_SIZE,
  parameter  int STEP = DEF_K,
  localparam int BIT  = addr_w(SIZE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_clr,
  input  logic           i_adv,
  output logic [BIT-1:0] o_ptr
);

  // A step of exactly SIZE is a full lap and leaves the pointer where it was.
  localparam logic [BIT-1:0] STEP_W = BIT'(STEP % SIZE);

  logic [BIT-1:0] r_ptr;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create order races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= r_ptr + STEP_W;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/buffer_ctrl.sv
// -----------------------------------------------------------------------------
// buffer_ctrl
// Pointer/occupancy controller for a circular buffer of SIZE words. Accepts
// K-word writes and issues J-word reads through valid/ready handshakes, drives
// the buffer's write strobe and base addresses, and tracks the fill level.
// Optional feature macro: BUF_CTRL_FLUSH_EN (adds the synchronous flush port).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   flush      in   synchronous clear (only with BUF_CTRL_FLUSH_EN)
//   in_valid   in   producer presents K words
//   in_ready   out  room for K more words (count <= SIZE-K)
//   out_valid  out  at least J words held (count >= J)
//   out_ready  in   consumer takes J words this cycle
//   ld         out  buffer write strobe (write handshake fires)
//   write_add  out  buffer write base address (registered)
//   read_add   out  buffer read base address (registered)
//   count      out  words held, 0..SIZE
//   full       out  count == SIZE
//   empty      out  count == 0
// -----------------------------------------------------------------------------
module buffer_ctrl
  import buffer_ctrl_pkg::*;
#(
  parameter  int SIZE  = DEF_SIZE,
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int K     = DEF_K,
  parameter  int J     = DEF_J,
  localparam int BIT   = addr_w(SIZE),
  localparam int CNT_W = cnt_w(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef BUF_CTRL_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ld,
  output logic [BIT-1:0]   write_add,
  output logic [BIT-1:0]   read_add,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  if (WIDTH < 1 || K < 1 || K > SIZE || J < 1 || J > SIZE || SIZE < 2 ||
      (SIZE & (SIZE - 1)) != 0) begin : g_bad_param
    $error("buffer_ctrl: illegal parameter set");
  end

  localparam logic [CNT_W-1:0] SIZE_C  = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] K_C     = CNT_W'(K);
  localparam logic [CNT_W-1:0] J_C     = CNT_W'(J);
  localparam logic [CNT_W-1:0] ROOM_C  = CNT_W'(SIZE - K);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_flush;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_wr;
  logic             w_rd;
  op_e              w_op;

`ifdef BUF_CTRL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Handshake qualifiers come from the pre-update count only.
  assign w_in_ready  = (r_count <= ROOM_C);
  assign w_out_valid = (r_count >= J_C);

  // Flush wins over any same-cycle transfer, so neither handshake fires.
  assign w_wr = in_valid  & w_in_ready  & ~w_flush;
  assign w_rd = out_ready & w_out_valid & ~w_flush;
  assign w_op = op_e'({w_rd, w_wr});

  // NOTE: every always_comb output gets a default first; a path that leaves
  // it unassigned would infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    unique case (w_op)
      OP_WR:   w_count_nxt = r_count + K_C;
      OP_RD:   w_count_nxt = r_count - J_C;
      OP_BOTH: w_count_nxt = r_count + K_C - J_C;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_flush) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  buffer_ctrl_mod_ptr #(.SIZE(SIZE), .STEP(K)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_flush),
    .i_adv (w_wr),
    .o_ptr (write_add)
  );

  buffer_ctrl_mod_ptr #(.SIZE(SIZE), .STEP(J)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_flush),
    .i_adv (w_rd),
    .o_ptr (read_add)
  );

  // The strobe is gated by reset so a handshake in flight when reset lands is
  // dropped immediately rather than at the next edge.
  assign ld        = w_wr & rst;
  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign count     = r_count;
  assign full      = (r_count == SIZE_C);
  assign empty     = (r_count == '0);

  a_count_range : assert property (@(posedge clk) disable iff (!rst)
                                   (r_count <= SIZE_C));

endmodule

// File: tb/tb_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_buffer_ctrl
// Directed self-checking bench for buffer_ctrl with SIZE=16, K=4, J=8.
// Inputs change 1 ns after a rising edge; outputs are sampled before the next
// rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_buffer_ctrl;

  localparam int SIZE  = 16;
  localparam int WIDTH = 8;
  localparam int K     = 4;
  localparam int J     = 8;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       ld;
  logic [3:0] write_add;
  logic [3:0] read_add;
  logic [4:0] count;
  logic       full;
  logic       empty;
`ifdef BUF_CTRL_FLUSH_EN
  logic       flush;
`endif

  int checks;
  int failures;

  buffer_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH), .K(K), .J(J)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef BUF_CTRL_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ld        (ld),
    .write_add (write_add),
    .read_add  (read_add),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef BUF_CTRL_FLUSH_EN
    flush = 1'b0;
`endif
    #3;
    checks++; if (write_add !== 4'd0) begin failures++; $display("FAIL reset_write_add got=%0d exp=0", write_add); end
    checks++; if (read_add !== 4'd0) begin failures++; $display("FAIL reset_read_add got=%0d exp=0", read_add); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (ld !== 1'b0) begin failures++; $display("FAIL reset_ld got=%b exp=0", ld); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  // Four K-word writes fill the 16-word buffer; write_add walks 0,4,8,12 and wraps.
  task automatic test_fill();
    logic [3:0] exp_wa;
    for (int i = 0; i < 4; i++) begin
      exp_wa = 4'(4 * i);
      in_valid = 1'b1;
      #1;
      checks++; if (ld !== 1'b1) begin failures++; $display("FAIL fill_ld[%0d] got=%b exp=1", i, ld); end
      checks++; if (write_add !== exp_wa) begin failures++; $display("FAIL fill_write_add[%0d] got=%0d exp=%0d", i, write_add, exp_wa); end
      step();
    end
    checks++; if (write_add !== 4'd0) begin failures++; $display("FAIL fill_wrap got=%0d exp=0", write_add); end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", count); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    checks++; if (ld !== 1'b0) begin failures++; $display("FAIL fill_5th_ld got=%b exp=0", ld); end
    step();
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_5th_count got=%0d exp=16", count); end
    checks++; if (write_add !== 4'd0) begin failures++; $display("FAIL fill_5th_write_add got=%0d exp=0", write_add); end
    in_valid = 1'b0;
  endtask

  // Two J-word reads empty the buffer; a further out_ready is ignored.
  task automatic test_drain();
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL drain_out_valid0 got=%b exp=1", out_valid); end
    checks++; if (read_add !== 4'd0) begin failures++; $display("FAIL drain_read_add0 got=%0d exp=0", read_add); end
    step();
    checks++; if (count !== 5'd8) begin failures++; $display("FAIL drain_count1 got=%0d exp=8", count); end
    checks++; if (read_add !== 4'd8) begin failures++; $display("FAIL drain_read_add1 got=%0d exp=8", read_add); end
    step();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL drain_count2 got=%0d exp=0", count); end
    checks++; if (read_add !== 4'd0) begin failures++; $display("FAIL drain_read_add2 got=%0d exp=0", read_add); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_out_valid got=%b exp=0", out_valid); end
    step();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL drain_idle_count got=%0d exp=0", count); end
    checks++; if (read_add !== 4'd0) begin failures++; $display("FAIL drain_idle_read_add got=%0d exp=0", read_add); end
    out_ready = 1'b0;
  endtask

  // From count=8: write and read in the same cycle gives count 4.
  task automatic test_simultaneous();
    in_valid = 1'b1;
    step();
    step();
    checks++; if (count !== 5'd8) begin failures++; $display("FAIL simul_pre_count got=%0d exp=8", count); end
    out_ready = 1'b1;
    #1;
    checks++; if (ld !== 1'b1) begin failures++; $display("FAIL simul_ld got=%b exp=1", ld); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL simul_out_valid got=%b exp=1", out_valid); end
    step();
    checks++; if (count !== 5'd4) begin failures++; $display("FAIL simul_count got=%0d exp=4", count); end
    checks++; if (write_add !== 4'd12) begin failures++; $display("FAIL simul_write_add got=%0d exp=12", write_add); end
    checks++; if (read_add !== 4'd8) begin failures++; $display("FAIL simul_read_add got=%0d exp=8", read_add); end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  // Threshold edges: out_valid off below J, in_ready on exactly at SIZE-K,
  // a rejected write leaves state alone, and a read reopens the input.
  task automatic test_back_to_back();
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bnd_out_valid_at4 got=%b exp=0", out_valid); end
    step();
    checks++; if (count !== 5'd4) begin failures++; $display("FAIL bnd_ignored_read_count got=%0d exp=4", count); end
    checks++; if (read_add !== 4'd8) begin failures++; $display("FAIL bnd_ignored_read_add got=%0d exp=8", read_add); end
    out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bnd_out_valid_at8 got=%b exp=1", out_valid); end
    checks++; if (write_add !== 4'd0) begin failures++; $display("FAIL bnd_write_add_wrap got=%0d exp=0", write_add); end
    step();
    checks++; if (count !== 5'd12) begin failures++; $display("FAIL bnd_count12 got=%0d exp=12", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bnd_in_ready_at12 got=%b exp=1", in_ready); end
    checks++; if (ld !== 1'b1) begin failures++; $display("FAIL bnd_ld_at12 got=%b exp=1", ld); end
    step();
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL bnd_count16 got=%0d exp=16", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bnd_in_ready_at16 got=%b exp=0", in_ready); end
    checks++; if (ld !== 1'b0) begin failures++; $display("FAIL bnd_reject_ld got=%b exp=0", ld); end
    step();
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL bnd_reject_count got=%0d exp=16", count); end
    checks++; if (write_add !== 4'd8) begin failures++; $display("FAIL bnd_reject_write_add got=%0d exp=8", write_add); end
    out_ready = 1'b1;
    #1;
    checks++; if (ld !== 1'b0) begin failures++; $display("FAIL bnd_read_cycle_ld got=%b exp=0", ld); end
    step();
    checks++; if (count !== 5'd8) begin failures++; $display("FAIL bnd_after_read_count got=%0d exp=8", count); end
    checks++; if (read_add !== 4'd0) begin failures++; $display("FAIL bnd_read_add_wrap got=%0d exp=0", read_add); end
    out_ready = 1'b0;
    #1;
    checks++; if (ld !== 1'b1) begin failures++; $display("FAIL bnd_reaccept_ld got=%b exp=1", ld); end
    step();
    checks++; if (count !== 5'd12) begin failures++; $display("FAIL bnd_reaccept_count got=%0d exp=12", count); end
    checks++; if (write_add !== 4'd12) begin failures++; $display("FAIL bnd_reaccept_write_add got=%0d exp=12", write_add); end
    in_valid = 1'b0;
  endtask

  // Reset pulsed mid-cycle at count=12 with both handshakes pending.
  task automatic test_reset_mid_burst();
    in_valid = 1'b1;
    out_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    checks++; if (write_add !== 4'd0) begin failures++; $display("FAIL rstmid_write_add got=%0d exp=0", write_add); end
    checks++; if (read_add !== 4'd0) begin failures++; $display("FAIL rstmid_read_add got=%0d exp=0", read_add); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (ld !== 1'b0) begin failures++; $display("FAIL rstmid_ld got=%b exp=0", ld); end
    step();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL rstmid_hold_count got=%0d exp=0", count); end
    checks++; if (write_add !== 4'd0) begin failures++; $display("FAIL rstmid_hold_write_add got=%0d exp=0", write_add); end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL rstmid_release_count got=%0d exp=0", count); end
  endtask

`ifdef BUF_CTRL_FLUSH_EN
  // Flush at count=12 beats a same-cycle write and read.
  task automatic test_flush();
    in_valid = 1'b1;
    step();
    step();
    step();
    checks++; if (count !== 5'd12) begin failures++; $display("FAIL flush_pre_count got=%0d exp=12", count); end
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (ld !== 1'b0) begin failures++; $display("FAIL flush_ld got=%b exp=0", ld); end
    step();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (write_add !== 4'd0) begin failures++; $display("FAIL flush_write_add got=%0d exp=0", write_add); end
    checks++; if (read_add !== 4'd0) begin failures++; $display("FAIL flush_read_add got=%0d exp=0", read_add); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", empty); end
    flush = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++; if (ld !== 1'b1) begin failures++; $display("FAIL flush_after_ld got=%b exp=1", ld); end
    step();
    checks++; if (count !== 5'd4) begin failures++; $display("FAIL flush_after_count got=%0d exp=4", count); end
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef BUF_CTRL_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
